// File: rtl/corr_sync_array.sv
// Bank of independent stochastic-bitstream correlation manipulators.
// Each channel holds up to DEPTH 1s of the leading stream to push the pair toward SCC=+1 (sync) or -1 (desync).
module corr_sync_array #(
   parameter int CH      = 1,
   parameter int DEPTH   = 2,
   parameter int OUT_REG = 0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          clr,
   input  logic [CH-1:0] mode,
   input  logic [CH-1:0] in_a,
   input  logic [CH-1:0] in_b,
   output logic [CH-1:0] out_a,
   output logic [CH-1:0] out_b,
   output logic          out_valid,
   output logic [CH-1:0] held
);

   localparam int BW = $clog2(DEPTH + 1) + 1;
   localparam logic signed [BW-1:0] BAL_MAX = BW'(DEPTH);
   localparam logic signed [BW-1:0] BAL_MIN = -BAL_MAX;
   localparam logic signed [BW-1:0] BAL_ONE = BW'(1);

   logic [CH-1:0] oa_comb;
   logic [CH-1:0] ob_comb;

   generate
      for (genvar gi = 0; gi < CH; gi++) begin : g_ch
         logic signed [BW-1:0] bal_reg;
         logic signed [BW-1:0] bal_next;
         logic                 oa;
         logic                 ob;
         logic                 pos;
         logic                 neg;
         logic                 at_max;
         logic                 at_min;

         assign neg    = bal_reg[BW-1];
         assign pos    = !bal_reg[BW-1] && (bal_reg != '0);
         assign at_max = (bal_reg == BAL_MAX);
         assign at_min = (bal_reg == BAL_MIN);

         always_comb begin
            oa       = 1'b0;
            ob       = 1'b0;
            bal_next = bal_reg;
            if (en) begin
               if (!mode[gi]) begin
                  // Sync: a lone 1 pairs with a held 1 of the other stream, else is held if room remains.
                  case ({in_a[gi], in_b[gi]})
                     2'b10: begin
                        if (neg) begin
                           oa       = 1'b1;
                           ob       = 1'b1;
                           bal_next = bal_reg + BAL_ONE;
                        end else if (!at_max) begin
                           bal_next = bal_reg + BAL_ONE;
                        end else begin
                           oa = 1'b1;
                        end
                     end
                     2'b01: begin
                        if (pos) begin
                           oa       = 1'b1;
                           ob       = 1'b1;
                           bal_next = bal_reg - BAL_ONE;
                        end else if (!at_min) begin
                           bal_next = bal_reg - BAL_ONE;
                        end else begin
                           ob = 1'b1;
                        end
                     end
                     default: begin
                        oa = in_a[gi];
                        ob = in_b[gi];
                     end
                  endcase
               end else begin
                  // Desync: overlapping 1s are split, one held and released on a later idle cycle.
                  case ({in_a[gi], in_b[gi]})
                     2'b11: begin
                        if (at_max || at_min) begin
                           oa = 1'b1;
                           ob = 1'b1;
                        end else if (pos) begin
                           ob       = 1'b1;
                           bal_next = bal_reg + BAL_ONE;
                        end else begin
                           oa       = 1'b1;
                           bal_next = bal_reg - BAL_ONE;
                        end
                     end
                     2'b00: begin
                        if (pos) begin
                           oa       = 1'b1;
                           bal_next = bal_reg - BAL_ONE;
                        end else if (neg) begin
                           ob       = 1'b1;
                           bal_next = bal_reg + BAL_ONE;
                        end
                     end
                     default: begin
                        oa = in_a[gi];
                        ob = in_b[gi];
                     end
                  endcase
               end
            end
            if (clr) begin
               bal_next = '0;
            end
         end

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               bal_reg <= '0;
            end else begin
               bal_reg <= bal_next;
            end
         end

         assign held[gi]    = (bal_reg != '0);
         assign oa_comb[gi] = oa;
         assign ob_comb[gi] = ob;
      end
   endgenerate

   generate
      if (OUT_REG == 0) begin : g_out_comb
         assign out_a     = rst_n ? oa_comb : '0;
         assign out_b     = rst_n ? ob_comb : '0;
         assign out_valid = rst_n & en;
      end else begin : g_out_reg
         logic [CH-1:0] out_a_reg;
         logic [CH-1:0] out_b_reg;
         logic          out_valid_reg;

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               out_a_reg     <= '0;
               out_b_reg     <= '0;
               out_valid_reg <= 1'b0;
            end else begin
               out_a_reg     <= oa_comb;
               out_b_reg     <= ob_comb;
               out_valid_reg <= en;
            end
         end

         assign out_a     = out_a_reg;
         assign out_b     = out_b_reg;
         assign out_valid = out_valid_reg;
      end
   endgenerate

endmodule

// File: tb/tb_corr_sync_array.sv
// Bench for corr_sync_array: four instances (mixed DEPTH / OUT_REG) share stimulus and are checked
// every cycle against a balance-count model, plus literal expectations on instance 0/1 channel 0.
module tb_corr_sync_array;

   localparam int NI = 4;
   localparam int CH = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic       clr;
   logic [3:0] mode;
   logic [3:0] in_a;
   logic [3:0] in_b;
   logic [3:0] oa [NI];
   logic [3:0] ob [NI];
   logic [3:0] hd [NI];
   logic       ov [NI];

   always #5 clk = ~clk;

   corr_sync_array #(.CH(CH), .DEPTH(2), .OUT_REG(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode), .in_a(in_a), .in_b(in_b),
      .out_a(oa[0]), .out_b(ob[0]), .out_valid(ov[0]), .held(hd[0]));
   corr_sync_array #(.CH(CH), .DEPTH(2), .OUT_REG(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode), .in_a(in_a), .in_b(in_b),
      .out_a(oa[1]), .out_b(ob[1]), .out_valid(ov[1]), .held(hd[1]));
   corr_sync_array #(.CH(CH), .DEPTH(1), .OUT_REG(0)) dut2 (
      .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode), .in_a(in_a), .in_b(in_b),
      .out_a(oa[2]), .out_b(ob[2]), .out_valid(ov[2]), .held(hd[2]));
   corr_sync_array #(.CH(CH), .DEPTH(8), .OUT_REG(1)) dut3 (
      .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode), .in_a(in_a), .in_b(in_b),
      .out_a(oa[3]), .out_b(ob[3]), .out_valid(ov[3]), .held(hd[3]));

   function automatic int dep_of(input int i);
      case (i)
         0: return 2;
         1: return 2;
         2: return 1;
         default: return 8;
      endcase
   endfunction

   function automatic bit oreg_of(input int i);
      return (i == 1) || (i == 3);
   endfunction

   // Balance model: positive = a-1s owed, negative = b-1s owed.
   function automatic void rule(input int depth, input bit m, input bit a, input bit b,
                                input int bal, output bit xa, output bit xb, output int nb);
      int d;
      int r;
      xa = a;
      xb = b;
      nb = bal;
      if (!m) begin
         if (a != b) begin
            d = a ? 1 : -1;
            r = bal * d;
            if (r < 0) begin
               xa = 1; xb = 1; nb = bal + d;
            end else if (r < depth) begin
               xa = 0; xb = 0; nb = bal + d;
            end
         end
      end else if (a == b) begin
         if (a) begin
            if (bal != depth && bal != -depth) begin
               if (bal > 0) begin xa = 0; nb = bal + 1; end
               else begin xb = 0; nb = bal - 1; end
            end
         end else if (bal > 0) begin
            xa = 1; nb = bal - 1;
         end else if (bal < 0) begin
            xb = 1; nb = bal + 1;
         end
      end
   endfunction

   // Control written by the driver, read by the compare process.
   bit    checking = 0;
   bit    cons_on  = 0;
   bit    cons_chk = 0;
   bit    lit_on   = 0;
   int    lit_inst = 0;
   string lit_name = "";
   int    lit_xa, lit_xb, lit_xh, lit_xv;

   int vectors    = 0;
   int miscompares = 0;
   int mbal   [NI][CH];
   bit preg_a [NI][CH];
   bit preg_b [NI][CH];
   bit preg_v [NI];
   int cin_a  [NI][CH];
   int cin_b  [NI][CH];
   int cout_a [NI][CH];
   int cout_b [NI][CH];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s t=%0t got=%0d expected=%0d", nm, $time, got, exp);
      end
   endtask

   initial begin
      for (int i = 0; i < NI; i++) begin
         preg_v[i] = 0;
         for (int c = 0; c < CH; c++) begin
            mbal[i][c] = 0; preg_a[i][c] = 0; preg_b[i][c] = 0;
            cin_a[i][c] = 0; cin_b[i][c] = 0; cout_a[i][c] = 0; cout_b[i][c] = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (checking) begin
         if (lit_on) begin
            if (lit_xa >= 0) chk({lit_name, ".out_a"}, 32'(oa[lit_inst][0]), 32'(lit_xa));
            if (lit_xb >= 0) chk({lit_name, ".out_b"}, 32'(ob[lit_inst][0]), 32'(lit_xb));
            if (lit_xh >= 0) chk({lit_name, ".held"}, 32'(hd[lit_inst][0]), 32'(lit_xh));
            if (lit_xv >= 0) chk({lit_name, ".out_valid"}, 32'(ov[lit_inst]), 32'(lit_xv));
         end
         for (int i = 0; i < NI; i++) begin
            bit ev;
            ev = rst_n && en;
            chk($sformatf("i%0d.out_valid", i), 32'(ov[i]), 32'(oreg_of(i) ? preg_v[i] : ev));
            preg_v[i] = ev;
            for (int c = 0; c < CH; c++) begin
               bit xa, xb;
               int nb;
               if (ev) rule(dep_of(i), mode[c], in_a[c], in_b[c], mbal[i][c], xa, xb, nb);
               else begin xa = 0; xb = 0; nb = mbal[i][c]; end
               if (clr) nb = 0;
               if (!rst_n) nb = 0;
               chk($sformatf("i%0d.c%0d.out_a", i, c), 32'(oa[i][c]), 32'(oreg_of(i) ? preg_a[i][c] : xa));
               chk($sformatf("i%0d.c%0d.out_b", i, c), 32'(ob[i][c]), 32'(oreg_of(i) ? preg_b[i][c] : xb));
               chk($sformatf("i%0d.c%0d.held", i, c), 32'(hd[i][c]), 32'(mbal[i][c] != 0));
               if (nb > dep_of(i) || nb < -dep_of(i))
                  chk($sformatf("i%0d.c%0d.bal_range", i, c), 32'(nb), 32'(dep_of(i)));
               if (cons_on) begin
                  if (ev && in_a[c]) cin_a[i][c]++;
                  if (ev && in_b[c]) cin_b[i][c]++;
                  if (oa[i][c] === 1'b1) cout_a[i][c]++;
                  if (ob[i][c] === 1'b1) cout_b[i][c]++;
               end
               if (cons_chk) begin
                  chk($sformatf("i%0d.c%0d.conserve_a", i, c), 32'(cout_a[i][c]),
                      32'(cin_a[i][c] - (mbal[i][c] > 0 ? mbal[i][c] : 0)));
                  chk($sformatf("i%0d.c%0d.conserve_b", i, c), 32'(cout_b[i][c]),
                      32'(cin_b[i][c] - (mbal[i][c] < 0 ? -mbal[i][c] : 0)));
               end
               preg_a[i][c] = xa;
               preg_b[i][c] = xb;
               mbal[i][c]   = nb;
            end
         end
      end
   end

   task automatic cyc(input bit e, input bit c, input logic [3:0] m, input logic [3:0] a, input logic [3:0] b);
      @(posedge clk);
      #1;
      en = e; clr = c; mode = m; in_a = a; in_b = b;
      lit_on = 0; cons_chk = 0;
   endtask

   task automatic lit(input string nm, input int xa, input int xb, input int xh, input int xv);
      lit_name = nm; lit_xa = xa; lit_xb = xb; lit_xh = xh; lit_xv = xv; lit_on = 1;
   endtask

   // One enabled cycle on channel 0 of instance 0 with literal expectations.
   task automatic dv(input string nm, input bit m, input bit a, input bit b,
                     input int xa, input int xb, input int xh);
      cyc(1, 0, {3'b0, m}, {3'b0, a}, {3'b0, b});
      lit(nm, xa, xb, xh, 1);
   endtask

   initial begin
      rst_n = 0; en = 1; clr = 0; mode = '0; in_a = 4'hF; in_b = 4'hF;
      cyc(1, 0, 4'h0, 4'hF, 4'hF);
      checking = 1;
      lit("rst1", 0, 0, 0, 0);
      cyc(1, 0, 4'h0, 4'hF, 4'hF);
      lit_inst = 1;
      lit("rst2_reg", 0, 0, 0, 0);
      cyc(1, 0, 4'h0, 4'h0, 4'h0);
      rst_n = 1;
      lit("first_v0", -1, -1, 0, 0);
      cyc(1, 0, 4'h0, 4'h0, 4'h0);
      lit("first_v1", 0, 0, 0, 1);
      cyc(1, 0, 4'h0, 4'h0, 4'h0);
      lit_inst = 0;

      dv("sync_a", 0, 1, 0, 0, 0, 0);
      dv("sync_b", 0, 0, 0, 0, 0, 1);
      dv("sync_c", 0, 0, 1, 1, 1, 1);
      dv("sync_d", 0, 0, 0, 0, 0, 0);

      dv("sat_a", 0, 1, 0, 0, 0, 0);
      dv("sat_b", 0, 1, 0, 0, 0, 1);
      dv("sat_c", 0, 1, 0, 1, 0, 1);
      dv("sat_d", 0, 0, 1, 1, 1, 1);
      dv("sat_e", 0, 0, 1, 1, 1, 1);
      dv("sat_f", 0, 0, 0, 0, 0, 0);

      dv("des_a", 1, 1, 1, 1, 0, 0);
      dv("des_b", 1, 1, 1, 1, 0, 1);
      dv("des_c", 1, 1, 1, 1, 1, 1);
      dv("des_d", 1, 0, 0, 0, 1, 1);
      dv("des_e", 1, 0, 0, 0, 1, 1);
      dv("des_f", 1, 0, 0, 0, 0, 0);

      dv("mode_a", 0, 1, 0, 0, 0, 0);
      dv("mode_b", 1, 0, 0, 1, 0, 1);
      dv("mode_c", 1, 0, 0, 0, 0, 0);

      dv("en0_a", 0, 1, 0, 0, 0, 0);
      cyc(0, 0, 4'h0, 4'h1, 4'h0);
      lit("en0_b", 0, 0, 1, 0);
      dv("en0_c", 0, 0, 0, 0, 0, 1);

      dv("clr_a", 0, 1, 0, 0, 0, 1);
      cyc(1, 1, 4'h0, 4'h0, 4'h1);
      lit("clr_en", 1, 1, 1, 1);
      dv("clr_after", 0, 0, 0, 0, 0, 0);

      dv("clr0_a", 0, 1, 0, 0, 0, 0);
      cyc(0, 1, 4'h0, 4'h1, 4'h1);
      lit("clr_noen", 0, 0, 1, 0);
      dv("clr0_after", 0, 0, 0, 0, 0, 0);

      // Random phase: a ~ 0.5, b ~ 0.3, occasional mode flips and idle cycles.
      cyc(0, 1, 4'h0, 4'h0, 4'h0);
      begin
         logic [3:0] m, a, b;
         m = 4'($urandom);
         for (int k = 0; k < 4096; k++) begin
            for (int c = 0; c < CH; c++) begin
               if ($urandom_range(0, 63) == 0) m[c] = ~m[c];
               a[c] = 1'($urandom_range(0, 1));
               b[c] = ($urandom_range(0, 9) < 3);
            end
            cyc($urandom_range(0, 9) != 0, 0, m, a, b);
            cons_on = 1;
         end
      end
      cyc(0, 0, 4'h0, 4'h0, 4'h0);
      cyc(0, 0, 4'h0, 4'h0, 4'h0);
      cons_chk = 1;
      cyc(0, 0, 4'h0, 4'h0, 4'h0);
      @(posedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
